adc_sample_sequencer: RTL and testbench

Periodic sampling scheduler for the 4-channel 12-bit I2C ADC in the PLL loop. It generates the sample-rate tick and picks the next enabled channel round-robin. It issues one read transaction per tick to the I2C transaction engine, validates the returned word, and presents a tagged 12-bit sample to the loop filter / DAC path. It also handles NACK/timeout retry and reports overrun and error counts.

---
 rtl/adc_sample_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// Periodic sampling scheduler for the 4-channel I2C ADC: sample-rate tick, round-robin
// channel pick, one read per tick with NACK/timeout retry, and a tagged 12-bit sample out.
module adc_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [3:0]  ch_mask,
  output logic        xact_req,
  output logic [7:0]  xact_cfg,
  input  logic        xact_ack,
  input  logic        xact_done,
  input  logic        xact_nack,
  input  logic [15:0] xact_data,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [1:0]  sample_ch,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  err_count
);

  localparam int unsigned TIMER_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TO_W    = 16;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    REQ       = 3'd2,
    WAIT_DONE = 3'd3,
    RETRY     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         ch_q, ch_d;
  logic [1:0]         last_ch_q, last_ch_d;
  logic               abort_q, abort_d;

  logic               xact_req_d;
  logic [7:0]         xact_cfg_d;
  logic               sample_valid_d;
  logic [11:0]        sample_data_d;
  logic [1:0]         sample_ch_d;
  logic               busy_d;
  logic               overrun_d;
  logic [7:0]         err_count_d;

  logic               tick_c;
  logic               mask_any_c;
  logic               resp_good_c;
  logic               timeout_c;
  logic               finish_c;
  logic [1:0]         next_ch_c;

  // First enabled channel after 'last', searching upward with wrap.
  function automatic logic [1:0] pick_next(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] cand;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && mask[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign tick_c      = EN && (timer_q == TIMER_W'(SAMPLE_DIV - 1));
  assign mask_any_c  = |ch_mask;
  assign next_ch_c   = pick_next(last_ch_q, ch_mask);
  assign resp_good_c = !xact_nack && (xact_data[15:14] == 2'b00) && (xact_data[13:12] == ch_q);
  assign timeout_c   = (state_q == WAIT_DONE) && (to_cnt_q == TO_W'(TIMEOUT));

  // Sample-rate timer, free-running while enabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_q <= '0;
    end else if (!EN || tick_c) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      retry_q      <= '0;
      ch_q         <= '0;
      last_ch_q    <= 2'd3;
      abort_q      <= 1'b0;
      xact_req     <= 1'b0;
      xact_cfg     <= 8'h00;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
      ch_q         <= ch_d;
      last_ch_q    <= last_ch_d;
      abort_q      <= abort_d;
      xact_req     <= xact_req_d;
      xact_cfg     <= xact_cfg_d;
      sample_valid <= sample_valid_d;
      sample_data  <= sample_data_d;
      sample_ch    <= sample_ch_d;
      busy         <= busy_d;
      overrun      <= overrun_d;
      err_count    <= err_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    retry_d        = retry_q;
    ch_d           = ch_q;
    last_ch_d      = last_ch_q;
    abort_d        = abort_q;
    xact_req_d     = 1'b0;
    xact_cfg_d     = xact_cfg;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data;
    sample_ch_d    = sample_ch;
    err_count_d    = err_count;
    overrun_d      = overrun;
    finish_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (EN) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!EN) begin
          state_d = IDLE;
        end else if (tick_c && mask_any_c) begin
          ch_d       = next_ch_c;
          retry_d    = '0;
          abort_d    = 1'b0;
          xact_cfg_d = {4'(4'b0001 << next_ch_c), 4'b0000};
          xact_req_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        // Ack wins over a concurrent EN drop: once accepted, the transfer runs to completion.
        if (xact_ack) begin
          to_cnt_d = TO_W'(1);
          if (xact_done) begin
            finish_c = 1'b1;
          end else begin
            abort_d = !EN;
            state_d = WAIT_DONE;
          end
        end else if (!EN) begin
          state_d = IDLE;
        end else begin
          xact_req_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (xact_done || timeout_c) begin
          finish_c = 1'b1;
        end else if (!EN) begin
          abort_d = 1'b1;
        end
      end
      RETRY: begin
        if (!EN) begin
          state_d = IDLE;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d    = retry_q + RETRY_W'(1);
          xact_req_d = 1'b1;
          state_d    = REQ;
        end else begin
          if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
          last_ch_d = ch_q;
          state_d   = WAIT_TICK;
        end
      end
      default: state_d = IDLE;
    endcase

    // Transfer finished (done or timeout): publish, retry, or discard if EN dropped.
    if (finish_c) begin
      abort_d = 1'b0;
      if (abort_q || !EN) begin
        state_d = IDLE;
      end else if (xact_done && resp_good_c) begin
        sample_data_d  = xact_data[11:0];
        sample_ch_d    = ch_q;
        sample_valid_d = 1'b1;
        last_ch_d      = ch_q;
        state_d        = WAIT_TICK;
      end else begin
        state_d = RETRY;
      end
    end

    busy_d = (state_d == REQ) || (state_d == WAIT_DONE) || (state_d == RETRY);

    if (!EN) begin
      overrun_d = 1'b0;
    end else if (tick_c && busy) begin
      overrun_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer: a scripted I2C engine drives responses and
// queues the samples it expects; a monitor pops and compares them on sample_valid.
module tb_adc_sample_sequencer;

  localparam int DIV   = 200;
  localparam int TO    = 50;
  localparam int MR    = 3;
  localparam int BOUND = 3 * DIV;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [3:0]  ch_mask;
  logic        xact_req;
  logic [7:0]  xact_cfg;
  logic        xact_ack;
  logic        xact_done;
  logic        xact_nack;
  logic [15:0] xact_data;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic [1:0]  sample_ch;
  logic        busy;
  logic        overrun;
  logic [7:0]  err_count;

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          cyc       = 0;
  int          req_cyc   = 0;
  int          en_up_cyc = 0;
  logic [13:0] exp_q[$];
  logic [13:0] sb_e;
  int          seq_a[5]  = '{0, 1, 2, 3, 0};
  int          seq_b[4]  = '{2, 0, 2, 0};

  adc_sample_sequencer #(
    .SAMPLE_DIV(DIV),
    .TIMEOUT   (TO),
    .MAX_RETRY (MR)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .ch_mask     (ch_mask),
    .xact_req    (xact_req),
    .xact_cfg    (xact_cfg),
    .xact_ack    (xact_ack),
    .xact_done   (xact_done),
    .xact_nack   (xact_nack),
    .xact_data   (xact_data),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ch   (sample_ch),
    .busy        (busy),
    .overrun     (overrun),
    .err_count   (err_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
  endtask

  function automatic logic [7:0] cfg_of(input logic [1:0] ch);
    case (ch)
      2'd0:    return 8'h10;
      2'd1:    return 8'h20;
      2'd2:    return 8'h40;
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [15:0] good_word(input logic [1:0] ch);
    logic [11:0] v;
    v = 12'($urandom_range(1, 4095));
    return {2'b00, ch, v};
  endfunction

  // One engine transaction: wait for req, ack (optionally late), then done or silence.
  task automatic serve(input logic [1:0] ch, input logic nack, input logic [15:0] data,
                       input int done_dly, input bit no_done, input bit good,
                       input int exp_wait, input int ack_dly, input int drop_at);
    int t;
    t = 0;
    while (xact_req !== 1'b1 && t < BOUND) begin
      step();
      t++;
    end
    check("req_seen", 32'(t < BOUND), 32'd1);
    if (t >= BOUND) return;
    req_cyc = cyc;
    if (exp_wait >= 0) check("req_latency", 32'(t), 32'(exp_wait));
    check("cfg", 32'(xact_cfg), 32'(cfg_of(ch)));
    for (int i = 0; i < ack_dly; i++) step();
    if (ack_dly > 0) begin
      check("req_hold", 32'(xact_req), 32'd1);
      check("cfg_hold", 32'(xact_cfg), 32'(cfg_of(ch)));
      check("busy_hold", 32'(busy), 32'd1);
    end
    xact_ack = 1'b1;
    if (no_done) begin
      step();
      xact_ack = 1'b0;
      for (int d = 1; d < TO; d++) step();
      step();
      check("to_no_early_retry", 32'(xact_req), 32'd0);
      check("to_no_valid", 32'(sample_valid), 32'd0);
    end else begin
      for (int d = 0; d < done_dly; d++) begin
        step();
        xact_ack = 1'b0;
        if (drop_at >= 0) begin
          if (d + 1 == drop_at) begin
            EN = 1'b0;
          end else if (d == drop_at) begin
            EN = 1'b1;
            en_up_cyc = cyc;
          end
        end
      end
      xact_done = 1'b1;
      xact_nack = nack;
      xact_data = data;
      if (good) exp_q.push_back({ch, data[11:0]});
      step();
      xact_ack  = 1'b0;
      xact_done = 1'b0;
      xact_nack = 1'b0;
      xact_data = 16'h0000;
      check("valid_timing", 32'(sample_valid), 32'(good));
    end
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_valid", 32'(sample_valid), 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_ch", 32'(sample_ch), 32'(sb_e[13:12]));
          check("sb_data", 32'(sample_data), 32'(sb_e[11:0]));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int reqs;
    int t;
    RST = 1'b1; EN = 1'b0; ch_mask = 4'hF;
    xact_ack = 1'b0; xact_done = 1'b0; xact_nack = 1'b0; xact_data = 16'h0000;
    repeat (3) step();
    check("rst_req", 32'(xact_req), 32'd0);
    check("rst_cfg", 32'(xact_cfg), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_ch", 32'(sample_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);

    // Full mask round robin.
    RST = 1'b0; EN = 1'b1;
    for (int k = 0; k < 5; k++)
      serve(2'(seq_a[k]), 1'b0, good_word(2'(seq_a[k])), 40, 1'b0, 1'b1,
            (k == 0) ? DIV : DIV - 41, 0, -1);

    // Sparse mask, then an empty mask.
    ch_mask = 4'b0101;
    for (int k = 0; k < 4; k++)
      serve(2'(seq_b[k]), 1'b0, good_word(2'(seq_b[k])), 10, 1'b0, 1'b1,
            (k == 0) ? DIV - 41 : DIV - 11, 0, -1);
    ch_mask = 4'b0000;
    reqs = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      if (xact_req === 1'b1 || busy === 1'b1) reqs++;
    end
    check("mask0_no_req", 32'(reqs), 32'd0);
    check("mask0_err", 32'(err_count), 32'd0);

    // NACK twice then good; NACK on every attempt skips the channel.
    ch_mask = 4'b1111;
    serve(2'd1, 1'b1, good_word(2'd1), 5, 1'b0, 1'b0, -1, 0, -1);
    serve(2'd1, 1'b1, good_word(2'd1), 5, 1'b0, 1'b0, 1, 0, -1);
    serve(2'd1, 1'b0, good_word(2'd1), 5, 1'b0, 1'b1, 1, 0, -1);
    check("nack2_err", 32'(err_count), 32'd0);
    serve(2'd2, 1'b1, good_word(2'd2), 5, 1'b0, 1'b0, -1, 0, -1);
    for (int k = 0; k < 3; k++) serve(2'd2, 1'b1, good_word(2'd2), 5, 1'b0, 1'b0, 1, 0, -1);
    step();
    check("skip_err", 32'(err_count), 32'd1);
    check("skip_no_req", 32'(xact_req), 32'd0);
    serve(2'd3, 1'b0, good_word(2'd3), 5, 1'b0, 1'b1, -1, 0, -1);

    // Timeout, channel-ID mismatch and bad top bits each retry once.
    serve(2'd0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, -1, 0, -1);
    serve(2'd0, 1'b0, good_word(2'd0), 5, 1'b0, 1'b1, 1, 0, -1);
    serve(2'd1, 1'b0, 16'h2ABC, 5, 1'b0, 1'b0, -1, 0, -1);
    serve(2'd1, 1'b0, good_word(2'd1), 5, 1'b0, 1'b1, 1, 0, -1);
    serve(2'd2, 1'b0, 16'h6ABC, 5, 1'b0, 1'b0, -1, 0, -1);
    serve(2'd2, 1'b0, good_word(2'd2), 5, 1'b0, 1'b1, 1, 0, -1);
    check("bad_resp_err", 32'(err_count), 32'd1);

    // Overrun from a slow ack; a one-cycle EN drop clears it and discards the in-flight read.
    serve(2'd3, 1'b0, good_word(2'd3), 5, 1'b0, 1'b1, -1, DIV + 5, -1);
    check("overrun_set", 32'(overrun), 32'd1);
    repeat (50) step();
    check("overrun_sticky", 32'(overrun), 32'd1);
    serve(2'd0, 1'b0, good_word(2'd0), 30, 1'b0, 1'b0, -1, 0, 10);
    check("overrun_clr", 32'(overrun), 32'd0);
    serve(2'd0, 1'b0, good_word(2'd0), 10, 1'b0, 1'b1, -1, 0, -1);
    check("en_restart_latency", 32'(req_cyc - en_up_cyc), 32'(DIV));

    // Reset while waiting for done.
    t = 0;
    while (xact_req !== 1'b1 && t < BOUND) begin
      step();
      t++;
    end
    check("rst_mid_req_seen", 32'(t < BOUND), 32'd1);
    check("rst_mid_cfg", 32'(xact_cfg), 32'h20);
    xact_ack = 1'b1;
    step();
    xact_ack = 1'b0;
    repeat (4) step();
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_mid_req", 32'(xact_req), 32'd0);
    check("rst_mid_cfg0", 32'(xact_cfg), 32'd0);
    check("rst_mid_valid", 32'(sample_valid), 32'd0);
    check("rst_mid_data", 32'(sample_data), 32'd0);
    check("rst_mid_ch", 32'(sample_ch), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_overrun", 32'(overrun), 32'd0);
    check("rst_mid_err", 32'(err_count), 32'd0);
    step();
    RST = 1'b0;
    serve(2'd0, 1'b0, good_word(2'd0), 10, 1'b0, 1'b1, DIV, 0, -1);

    repeat (5) step();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
